// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants, state encoding and F/D entry layout for the fetch stage
package fetch_stage_pkg;
    localparam int PC_W = 32;
    localparam int INST_W = 32;
    localparam logic [PC_W-1:0] PC_START = 32'h01000000;
    localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;
    localparam logic [PC_W-1:0] INST_BYTES = 32'd4;
    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
    typedef struct packed {
        logic valid;
        logic [PC_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic misaligned;
    } fd_entry_t;
endpackage

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register, next-PC selection, BOOT/RUN/FAULT sequencing and misalignment check
module fetch_pc_unit
    import fetch_stage_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            advance,
    output logic [PC_W-1:0] pc,
    output logic            capture,
    output logic            fault_emit
);
    state_t state;
    logic pending;
    logic misaligned_target;
    assign misaligned_target = |redirect_pc[1:0];
    assign capture = !redirect_valid && state == RUN && advance;
    // pending marks the single fault entry still owed to decode after a misaligned redirect
    assign fault_emit = !redirect_valid && state == FAULT && pending && advance;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= PC_START;
            state <= BOOT;
            pending <= 1'b0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            state <= misaligned_target ? FAULT : RUN;
            pending <= misaligned_target;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: if (advance) pc <= pc + INST_BYTES;
                FAULT: if (advance) pending <= 1'b0;
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with F/D register, decode handshake, redirects and fetch statistics
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_inst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_misaligned,
    output logic [31:0]       fetch_count,
    output logic [31:0]       kill_count
);
    fd_entry_t fd;
    logic [PC_W-1:0] pc;
    logic advance;
    logic capture;
    logic fault_emit;
    assign advance = !fd.valid || out_ready;
    assign imem_addr = pc;
    assign out_valid = fd.valid;
    assign out_pc = fd.pc;
    assign out_inst = fd.inst;
    assign out_misaligned = fd.misaligned;
    fetch_pc_unit u_pc (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (advance),
        .pc             (pc),
        .capture        (capture),
        .fault_emit     (fault_emit)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fd <= '{valid: 1'b0, pc: '0, inst: NOP_INST, misaligned: 1'b0};
            fetch_count <= '0;
            kill_count <= '0;
        end else begin
            if (fd.valid && out_ready) fetch_count <= fetch_count + 32'd1;
            // an entry decode takes on the redirect edge is delivered, not killed
            if (redirect_valid && fd.valid && !out_ready) kill_count <= kill_count + 32'd1;
            if (redirect_valid) begin
                fd.valid <= 1'b0;
                fd.inst <= NOP_INST;
                fd.misaligned <= 1'b0;
            end else if (capture) begin
                fd <= '{valid: 1'b1, pc: pc, inst: imem_inst, misaligned: 1'b0};
            end else if (fault_emit) begin
                fd <= '{valid: 1'b1, pc: pc, inst: NOP_INST, misaligned: 1'b1};
            end else if (advance) begin
                fd.valid <= 1'b0;
                fd.inst <= NOP_INST;
                fd.misaligned <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenario checks of fetch_stage against hand-computed values
module tb_fetch_stage;
    logic        clock;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_misaligned;
    logic [31:0] fetch_count;
    logic [31:0] kill_count;
    int errors = 0;
    int checks = 0;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] BASE = 32'h01000000;
    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_misaligned (out_misaligned),
        .fetch_count    (fetch_count),
        .kill_count     (kill_count)
    );
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h01000000: return 32'h00500093;
            32'h01000004: return 32'h00a00113;
            32'h01000008: return 32'h002081b3;
            32'h0100000c: return 32'h40110233;
            default: return a ^ 32'hcafe0000;
        endcase
    endfunction
    always_comb imem_inst = mem_word(imem_addr);
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask
    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (out_inst !== NOP) begin errors++; $display("FAIL reset_inst got %h want %h", out_inst, NOP); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", out_pc); end
        checks++; if (imem_addr !== BASE) begin errors++; $display("FAIL reset_addr got %h want %h", imem_addr, BASE); end
        checks++; if (fetch_count !== 0 || kill_count !== 0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", fetch_count, kill_count); end
        reset = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got %0b want 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== BASE + 32'(4 * i) || out_inst !== mem_word(BASE + 32'(4 * i)) || out_misaligned !== 1'b0) begin
                errors++; $display("FAIL seq%0d got v=%0b pc=%h inst=%h want pc=%h inst=%h", i, out_valid, out_pc, out_inst, BASE + 32'(4 * i), mem_word(BASE + 32'(4 * i)));
            end
        end
        tick();
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL seq_fetch_count got %0d want 4", fetch_count); end
    endtask
    task automatic test_stall();
        do_reset();
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_pc !== 32'h01000004 || out_inst !== 32'h00a00113 || imem_addr !== 32'h01000008 || out_valid !== 1'b1) begin
                errors++; $display("FAIL stall%0d got pc=%h inst=%h addr=%h want 01000004/00a00113/01000008", i, out_pc, out_inst, imem_addr);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_pc !== 32'h01000008 || out_inst !== 32'h002081b3 || fetch_count !== 32'd2) begin
            errors++; $display("FAIL stall_release got pc=%h inst=%h cnt=%0d want 01000008/002081b3/2", out_pc, out_inst, fetch_count);
        end
        tick();
        checks++; if (out_pc !== 32'h0100000c || fetch_count !== 32'd3) begin errors++; $display("FAIL stall_next got pc=%h cnt=%0d want 0100000c/3", out_pc, fetch_count); end
    endtask
    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_pc = 32'h01000100;
        out_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || kill_count !== 32'd1 || fetch_count !== 32'd3 || imem_addr !== 32'h01000100) begin
            errors++; $display("FAIL redirect_kill got v=%0b kill=%0d fetch=%0d addr=%h want 0/1/3/01000100", out_valid, kill_count, fetch_count, imem_addr);
        end
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h01000100 || out_inst !== mem_word(32'h01000100)) begin
            errors++; $display("FAIL redirect_target got v=%0b pc=%h inst=%h want 1/01000100/%h", out_valid, out_pc, out_inst, mem_word(32'h01000100));
        end
    endtask
    task automatic test_misaligned();
        redirect_valid = 1'b1;
        redirect_pc = 32'h01000102;
        tick();
        checks++; if (out_valid !== 1'b0 || fetch_count !== 32'd4 || kill_count !== 32'd1) begin
            errors++; $display("FAIL accept_on_redirect got v=%0b fetch=%0d kill=%0d want 0/4/1", out_valid, fetch_count, kill_count);
        end
        redirect_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_misaligned !== 1'b1 || out_inst !== NOP || out_pc !== 32'h01000102) begin
            errors++; $display("FAIL fault_entry got v=%0b mis=%0b inst=%h pc=%h want 1/1/00000013/01000102", out_valid, out_misaligned, out_inst, out_pc);
        end
        tick();
        checks++; if (out_valid !== 1'b0 || out_misaligned !== 1'b0 || fetch_count !== 32'd5) begin
            errors++; $display("FAIL fault_accept got v=%0b mis=%0b fetch=%0d want 0/0/5", out_valid, out_misaligned, fetch_count);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h01000102) begin
                errors++; $display("FAIL fault_hold%0d got v=%0b addr=%h want 0/01000102", i, out_valid, imem_addr);
            end
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h01000200;
        tick();
        checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h01000200) begin errors++; $display("FAIL fault_exit got v=%0b addr=%h want 0/01000200", out_valid, imem_addr); end
        redirect_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h01000200 || out_misaligned !== 1'b0 || out_inst !== mem_word(32'h01000200)) begin
            errors++; $display("FAIL fault_resume got v=%0b pc=%h mis=%0b inst=%h want 1/01000200/0", out_valid, out_pc, out_misaligned, out_inst);
        end
    endtask
    task automatic test_async_reset();
        out_ready = 1'b0;
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_inst !== NOP || imem_addr !== BASE || fetch_count !== 0 || kill_count !== 0) begin
            errors++; $display("FAIL async_reset got v=%0b inst=%h addr=%h fetch=%0d kill=%0d", out_valid, out_inst, imem_addr, fetch_count, kill_count);
        end
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_boot got v=%0b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== BASE || out_inst !== 32'h00500093) begin
            errors++; $display("FAIL async_restart got v=%0b pc=%h inst=%h want 1/01000000/00500093", out_valid, out_pc, out_inst);
        end
    endtask
    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc = 32'hfffffffc;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hfffffffc || out_misaligned !== 1'b0) begin
            errors++; $display("FAIL wrap_last got v=%0b pc=%h mis=%0b want 1/fffffffc/0", out_valid, out_pc, out_misaligned);
        end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_misaligned !== 1'b0 || out_inst !== mem_word(32'h0) || imem_addr !== 32'h4) begin
            errors++; $display("FAIL wrap_zero got v=%0b pc=%h mis=%0b inst=%h addr=%h want 1/0/0/%h/4", out_valid, out_pc, out_misaligned, out_inst, imem_addr, mem_word(32'h0));
        end
    endtask
    task automatic test_boot_redirect();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'h01000300;
        tick();
        checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h01000300 || kill_count !== 0) begin
            errors++; $display("FAIL boot_redirect got v=%0b addr=%h kill=%0d want 0/01000300/0", out_valid, imem_addr, kill_count);
        end
        redirect_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h01000300) begin errors++; $display("FAIL boot_redirect_fetch got v=%0b pc=%h want 1/01000300", out_valid, out_pc); end
    endtask
    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_misaligned();
        test_async_reset();
        test_wrap();
        test_boot_redirect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
